// File: rtl/dft_sample_writer_pkg.sv
// Shared types and helpers for the DFT input-FIFO sample writer.
// Holds the FSM state type, decimator widths and the offset-binary to two's-complement helper.
package dft_sample_writer_pkg;

  localparam int DSH_W_DEF = 3;
  // Headroom bits for the averaging accumulator (2^(2^DSH_W - 1) samples at most).
  localparam int ACC_EXT   = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WIN_CHK,
    S_FILL,
    S_SKIP
  } state_t;

  // XOR mask that turns an offset-binary word of width w into two's complement.
  function automatic logic [31:0] offset_mask(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/dft_sample_writer_if.sv
// FIFO write port between the sample writer (master) and the DFT input FIFO (slave).
interface dft_sample_writer_if #(
  parameter int DATA_IN_W = 12,
  parameter int FREE_W    = 6
);
  logic [DATA_IN_W-1:0] fifo_wdata;
  logic                 fifo_wr;
  logic                 fifo_full;
  logic [FREE_W-1:0]    fifo_free;

  modport master (output fifo_wdata, output fifo_wr, input fifo_full, input fifo_free);
  modport slave  (input fifo_wdata, input fifo_wr, output fifo_full, output fifo_free);
endinterface

// File: rtl/dft_sample_writer_decimator.sv
// Decimate-by-2^dsh front end: phase counter plus, with DFT_SAMPLE_WRITER_AVG_EN, a group averager.
// Without the macro the first sample of each group is passed through combinationally.
module dft_sample_writer_decimator
  import dft_sample_writer_pkg::*;
#(
  parameter int DATA_IN_W = 12,
  parameter int DSH_W     = DSH_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [DSH_W-1:0]     dsh,
  input  logic [DATA_IN_W-1:0] adc_data,
  input  logic                 adc_valid,
  output logic [DATA_IN_W-1:0] smp_data,
  output logic                 smp_valid
);
  localparam int PH_W = (1 << DSH_W) - 1;
  localparam logic [DATA_IN_W-1:0] SIGN_FLIP = DATA_IN_W'(offset_mask(DATA_IN_W));

  logic [PH_W-1:0]      phase_q, phase_d, ph_last;
  logic [DATA_IN_W-1:0] conv;

  always_comb begin
    conv    = adc_data ^ SIGN_FLIP;
    ph_last = (PH_W'(1) << dsh) - PH_W'(1);
    phase_d = phase_q;
    if (clr)
      phase_d = '0;
    else if (adc_valid)
      phase_d = (phase_q == ph_last) ? '0 : phase_q + PH_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_d;
  end

`ifdef DFT_SAMPLE_WRITER_AVG_EN
  localparam int ACC_W = DATA_IN_W + ACC_EXT;

  logic signed [ACC_W-1:0] acc_q, acc_d, acc_base, acc_sum;
  logic [DATA_IN_W-1:0]    out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;

  always_comb begin
    // The first sample of a group restarts the sum rather than adding to it.
    acc_base    = (phase_q == '0) ? '0 : acc_q;
    acc_sum     = acc_base + ACC_W'(signed'(conv));
    acc_d       = adc_valid ? acc_sum : acc_q;
    out_valid_d = adc_valid && !clr && (phase_q == ph_last);
    out_data_d  = out_valid_d ? DATA_IN_W'(acc_sum >>> dsh) : out_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign smp_data  = out_data_q;
  assign smp_valid = out_valid_q;
`else
  assign smp_data  = conv;
  assign smp_valid = adc_valid && !clr && (phase_q == '0);
`endif

endmodule

// File: rtl/dft_sample_writer.sv
// Producer end of the DFT input FIFO: writes whole DFT_N-point windows of decimated, signed samples.
// Define DFT_SAMPLE_WRITER_AVG_EN to average each decimation group instead of picking its first sample.
module dft_sample_writer
  import dft_sample_writer_pkg::*;
#(
  parameter int DATA_IN_W = 12,
  parameter int DFT_N     = 16,
  parameter int FREE_W    = 6,
  parameter int WIN_W     = 16,
  parameter int DSH_W     = DSH_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_IN_W-1:0] adc_data,
  input  logic                 adc_valid,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DSH_W-1:0]     decim_sh,
  input  logic [WIN_W-1:0]     n_windows,
  dft_sample_writer_if.master  fifo,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          drop_cnt,
  output logic                 ovf_err
);
  localparam int PTS_W = $clog2(DFT_N + 1);
  localparam logic [PTS_W-1:0]  PTS_LAST = PTS_W'(DFT_N);
  localparam logic [FREE_W:0]   ROOM_MIN = (FREE_W + 1)'(DFT_N);

  state_t               state_q;
  logic                 busy_q, done_q, wr_q, ovf_q, stop_pend_q;
  logic [DATA_IN_W-1:0] wdata_q;
  logic [PTS_W-1:0]     pts_q;
  logic [WIN_W-1:0]     win_cnt_q, nwin_q;
  logic [DSH_W-1:0]     dsh_q;
  logic [15:0]          drop_q;

  logic                 start_ok, pend, win_last, room, pts_end;
  logic [DATA_IN_W-1:0] smp_data;
  logic                 smp_valid;

  always_comb begin
    start_ok = (state_q == S_IDLE) && start && !stop;
    pend     = stop_pend_q || stop;
    win_last = (nwin_q != '0) && (win_cnt_q + WIN_W'(1) == nwin_q);
    room     = {1'b0, fifo.fifo_free} >= ROOM_MIN;
    pts_end  = (pts_q + PTS_W'(1)) == PTS_LAST;
  end

  dft_sample_writer_decimator #(
    .DATA_IN_W (DATA_IN_W),
    .DSH_W     (DSH_W)
  ) u_decim (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok),
    .dsh       (dsh_q),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .smp_data  (smp_data),
    .smp_valid (smp_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      ovf_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      pts_q       <= '0;
      win_cnt_q   <= '0;
      nwin_q      <= '0;
      dsh_q       <= '0;
      drop_q      <= '0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      if (wr_q && fifo.fifo_full) ovf_q <= 1'b1;
      if (busy_q && stop)         stop_pend_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q     <= S_WIN_CHK;
            busy_q      <= 1'b1;
            dsh_q       <= decim_sh;
            nwin_q      <= n_windows;
            win_cnt_q   <= '0;
            drop_q      <= '0;
            ovf_q       <= 1'b0;
            stop_pend_q <= 1'b0;
          end
        end
        S_WIN_CHK: begin
          if (pend) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (smp_valid) begin
            pts_q <= PTS_W'(1);
            if (room) begin
              wr_q    <= 1'b1;
              wdata_q <= smp_data;
              // A one-point window is already complete on its first write.
              if (DFT_N == 1) begin
                win_cnt_q <= win_cnt_q + WIN_W'(1);
                if (win_last) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end else begin
                state_q <= S_FILL;
              end
            end else begin
              if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
              if (DFT_N != 1) state_q <= S_SKIP;
            end
          end
        end
        S_FILL: begin
          if (smp_valid) begin
            wr_q    <= 1'b1;
            wdata_q <= smp_data;
            pts_q   <= pts_q + PTS_W'(1);
            if (pts_end) begin
              win_cnt_q <= win_cnt_q + WIN_W'(1);
              if (win_last || pend) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_WIN_CHK;
              end
            end
          end
        end
        S_SKIP: begin
          if (smp_valid) begin
            pts_q <= pts_q + PTS_W'(1);
            if (pts_end) begin
              if (pend) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_WIN_CHK;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo.fifo_wdata = wdata_q;
  assign fifo.fifo_wr    = wr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign drop_cnt        = drop_q;
  assign ovf_err         = ovf_q;

endmodule

// File: tb/tb_dft_sample_writer.sv
// Self-checking bench for dft_sample_writer: directed captures with random data and a
// group/window reference model built from the capture rules (honours DFT_SAMPLE_WRITER_AVG_EN).
`timescale 1ns/1ps
module tb_dft_sample_writer;
  localparam int DW = 12;
  localparam int N  = 16;
  localparam int FW = 6;
  localparam int WW = 16;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] adc_data = '0;
  logic          adc_valid = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [SW-1:0] decim_sh = '0;
  logic [WW-1:0] n_windows = '0;
  logic          busy, done, ovf_err;
  logic [15:0]   drop_cnt;
  logic [FW-1:0] free_v = 6'd63;

  always #5 clk = ~clk;

  dft_sample_writer_if #(.DATA_IN_W(DW), .FREE_W(FW)) fif ();
  assign fif.fifo_free = free_v;

  dft_sample_writer #(
    .DATA_IN_W (DW),
    .DFT_N     (N),
    .FREE_W    (FW),
    .WIN_W     (WW),
    .DSH_W     (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .start     (start),
    .stop      (stop),
    .decim_sh  (decim_sh),
    .n_windows (n_windows),
    .fifo      (fif),
    .busy      (busy),
    .done      (done),
    .drop_cnt  (drop_cnt),
    .ovf_err   (ovf_err)
  );

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int full_at = 0;
  int ramp = 0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] raw_q[$];
  logic [DW-1:0] exp_q[$];

  // Write monitor; also asserts fifo_full during the full_at-th write of a capture.
  always @(negedge clk) begin
    fif.fifo_full = 1'b0;
    if (fif.fifo_wr) begin
      got_q.push_back(fif.fifo_wdata);
      if (full_at != 0 && got_q.size() == full_at) fif.fifo_full = 1'b1;
    end
    if (done) done_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_capture(input int sh, input int nw);
    decim_sh  = SW'(sh);
    n_windows = WW'(nw);
    start = 1'b1;
    tick();
    start = 1'b0;
    got_q.delete();
    raw_q.delete();
    done_cnt = 0;
  endtask

  task automatic feed(input int n, input bit rnd, input bit gaps, input int stop_at);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(2) == 0) begin
        adc_valid = 1'b0;
        tick();
      end
      adc_data  = rnd ? DW'($urandom) : DW'(ramp);
      ramp++;
      adc_valid = 1'b1;
      stop      = (i == stop_at);
      raw_q.push_back(adc_data);
      tick();
    end
    adc_valid = 1'b0;
    stop      = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
    chk({tag, " idle"}, 32'(busy), 32'd0);
    tick(2);
  endtask

  // Reference: one output per complete group of 2^sh samples (first sample, or floor mean).
  function automatic void build_exp(input int sh);
    exp_q.delete();
    for (int g = 0; ((g + 1) << sh) <= raw_q.size(); g++) begin
`ifdef DFT_SAMPLE_WRITER_AVG_EN
      int sum;
      sum = 0;
      for (int k = 0; k < (1 << sh); k++) sum += int'(raw_q[(g << sh) + k]) - 2048;
      exp_q.push_back(DW'(sum >>> sh));
`else
      exp_q.push_back(DW'(int'(raw_q[g << sh]) - 2048));
`endif
    end
  endfunction

  task automatic check_writes(input string tag, input int first, input int cnt);
    chk({tag, " count"}, 32'(got_q.size()), 32'(cnt));
    for (int i = 0; i < cnt && i < got_q.size() && first + i < exp_q.size(); i++)
      chk($sformatf("%s wr%0d", tag, i), 32'(got_q[i]), 32'(exp_q[first + i]));
    $display("capture %s: %0d writes observed, %0d expected, drop_cnt=%0d",
             tag, got_q.size(), cnt, drop_cnt);
  endtask

  initial begin
    int sh, nw;
    tick(2);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst wr", 32'(fif.fifo_wr), 0);
    chk("rst wdata", 32'(fif.fifo_wdata), 0);
    chk("rst drop", 32'(drop_cnt), 0);
    chk("rst ovf", 32'(ovf_err), 0);
    rst = 1'b0;
    tick(2);

    // Two windows of a ramp, no decimation.
    ramp = 0;
    begin_capture(0, 2);
    feed(36, 1'b0, 1'b0, -1);
    wait_idle("ramp");
    build_exp(0);
    check_writes("ramp", 0, 32);
    chk("ramp first", 32'(got_q[0]), 32'h800);
    chk("ramp done", 32'(done_cnt), 1);
    chk("ramp drop", 32'(drop_cnt), 0);

    // Decimate by 4 on a ramp 0..63.
    ramp = 0;
    begin_capture(2, 1);
    feed(72, 1'b0, 1'b0, -1);
    wait_idle("dec4");
    build_exp(2);
    check_writes("dec4", 0, 16);

    // Random decimation, window count, data and valid gaps.
    for (int r = 0; r < 3; r++) begin
      sh = $urandom_range(3);
      nw = $urandom_range(1, 3);
      begin_capture(sh, nw);
      feed((nw * N << sh) + 4, 1'b1, 1'b1, -1);
      wait_idle("rand");
      build_exp(sh);
      check_writes($sformatf("rand%0d sh%0d nw%0d", r, sh, nw), 0, nw * N);
      chk("rand done", 32'(done_cnt), 1);
    end

    // Not enough room for window 1: dropped whole, next window written.
    free_v = 6'd15;
    begin_capture(0, 1);
    feed(16, 1'b1, 1'b0, -1);
    tick(3);
    chk("drop nowr", 32'(got_q.size()), 0);
    chk("drop cnt", 32'(drop_cnt), 1);
    chk("drop busy", 32'(busy), 1);
    free_v = 6'd63;
    feed(20, 1'b1, 1'b0, -1);
    wait_idle("drop");
    build_exp(0);
    check_writes("drop", 16, 16);

    // Continuous capture, stop at point 5 of window 3: window 3 still completes.
    begin_capture(1, 0);
    feed((48 << 1) + 8, 1'b1, 1'b0, 36 << 1);
    wait_idle("stop");
    build_exp(1);
    check_writes("stop", 0, 48);
    chk("stop done", 32'(done_cnt), 1);
    chk("stop busy", 32'(busy), 0);

    // fifo_full during write 7: write still issued, sticky ovf_err cleared by start.
    full_at = 7;
    begin_capture(0, 1);
    feed(20, 1'b1, 1'b0, -1);
    wait_idle("ovf");
    full_at = 0;
    build_exp(0);
    check_writes("ovf", 0, 16);
    chk("ovf set", 32'(ovf_err), 1);
    tick(3);
    chk("ovf sticky", 32'(ovf_err), 1);
    begin_capture(0, 1);
    chk("ovf clr", 32'(ovf_err), 0);
    feed(20, 1'b1, 1'b0, -1);
    wait_idle("ovf2");
    chk("ovf2 stays 0", 32'(ovf_err), 0);

    // Reset mid-FILL, then a clean restart; a start pulse while busy is ignored.
    begin_capture(0, 1);
    feed(8, 1'b1, 1'b0, -1);
    rst = 1'b1;
    #1;
    chk("mid rst busy", 32'(busy), 0);
    chk("mid rst wr", 32'(fif.fifo_wr), 0);
    chk("mid rst wdata", 32'(fif.fifo_wdata), 0);
    chk("mid rst done", 32'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    begin_capture(0, 1);
    feed(4, 1'b1, 1'b0, -1);
    decim_sh = 3'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(16, 1'b1, 1'b0, -1);
    wait_idle("restart");
    build_exp(0);
    check_writes("restart", 0, 16);
    chk("restart done", 32'(done_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
